// File: rtl/instr_word_encoder.sv
// rtl/instr_word_encoder.sv - RV32I field encoder and instruction memory loader
module instr_word_encoder #(
    parameter int          ADDR_W    = 8,
    parameter logic [31:0] BASE_ADDR = 32'h0000_0000
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [1:0]        fmt,
    input  logic [6:0]        opcode,
    input  logic [2:0]        funct3,
    input  logic [6:0]        funct7,
    input  logic [4:0]        rd,
    input  logic [4:0]        rs1,
    input  logic [4:0]        rs2,
    input  logic [31:0]       imm,
    output logic              mem_we,
    output logic [31:0]       mem_addr,
    output logic [31:0]       mem_wdata,
    input  logic              mem_ack,
    output logic [ADDR_W:0]   count,
    output logic              full,
    output logic              err
);

    localparam int              CAP_INT = 1 << ADDR_W;
    localparam logic [ADDR_W:0] CAP     = CAP_INT[ADDR_W:0];

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_WRITE = 2'd1,
        S_FULL  = 2'd2
    } state_t;

    state_t state;
    state_t state_next;

    logic signed [31:0] imm_s;
    logic               imm12_ok;
    logic               imm13_ok;
    logic [31:0]        word;
    logic               legal;
    logic               accept;
    logic               ack_taken;
    logic [ADDR_W:0]    count_inc;

    assign imm_s     = imm;
    assign imm12_ok  = (imm_s >= -32'sd2048) && (imm_s <= 32'sd2047);
    assign imm13_ok  = (imm_s >= -32'sd4096) && (imm_s <= 32'sd4094) && !imm[0];
    assign accept    = in_valid && (state == S_IDLE);
    assign ack_taken = mem_ack && (state == S_WRITE);
    assign count_inc = count + 1'b1;

    // Pack the fields of the selected format and decide if the immediate fits without truncation
    always_comb begin
        word  = '0;
        legal = 1'b0;
        case (fmt)
            2'b00: begin
                word  = {imm[11:0], rs1, funct3, rd, opcode};
                legal = imm12_ok;
            end
            2'b01: begin
                word  = {imm[11:5], rs2, rs1, funct3, imm[4:0], opcode};
                legal = imm12_ok;
            end
            2'b10: begin
                word  = {imm[12], imm[10:5], rs2, rs1, funct3, imm[4:1], imm[11], opcode};
                legal = imm13_ok;
            end
            default: begin
                word  = {funct7, rs2, rs1, funct3, rd, opcode};
                legal = 1'b1;
            end
        endcase
    end

    // State register
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic: a write leaves for FULL when it fills the last slot
    always_comb begin
        state_next = state;
        case (state)
            S_IDLE:  if (accept && legal) state_next = S_WRITE;
            S_WRITE: if (mem_ack) state_next = (count_inc == CAP) ? S_FULL : S_IDLE;
            S_FULL:  state_next = S_FULL;
            default: state_next = S_IDLE;
        endcase
    end

    // State-decoded handshake and status outputs
    always_comb begin
        in_ready = (state == S_IDLE);
        mem_we   = (state == S_WRITE);
        full     = (state == S_FULL);
    end

    // Write datapath: capture the word on a legal handshake, advance address and count on ack
    always_ff @(posedge clk) begin
        if (reset) begin
            mem_addr  <= BASE_ADDR;
            mem_wdata <= '0;
            count     <= '0;
            err       <= 1'b0;
        end else begin
            if (accept) begin
                if (legal) begin
                    mem_wdata <= word;
                end else begin
                    err <= 1'b1;
                end
            end
            if (ack_taken) begin
                mem_addr <= mem_addr + 32'd4;
                count    <= count_inc;
            end
        end
    end

endmodule
